// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared constants and types for the five-stage RISC-V pipeline registers.
//   XLEN       - datapath width (PC, operands, immediate)
//   ALUOP_W    - ALU control field width
//   REG_ADD_W  - register address width
//   X0_ADD     - address of the hard-wired zero register
//   ctrl_flags_t / CTRL_W - single-bit control bundle and full control width
//                (flags + AluOp), also carried by EX/MEM
package pipeline_pkg;

    localparam int XLEN      = 32;
    localparam int ALUOP_W   = 4;
    localparam int REG_ADD_W = 5;
    localparam logic [REG_ADD_W-1:0] X0_ADD = 5'b0;

    typedef struct packed {
        logic alu_src;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic branch;
    } ctrl_flags_t;

    localparam int FLAGS_W = $bits(ctrl_flags_t);
    localparam int CTRL_W  = ALUOP_W + FLAGS_W;

endpackage

// File: rtl/comparator_nbit.sv
// Comparator_Nbit
// N-bit equality comparator shared by the hazard and forwarding logic.
//   a_i, b_i - operands
//   eq_o     - 1 when a_i == b_i
module Comparator_Nbit #(
    parameter int N = 5
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         eq_o
);

    assign eq_o = (a_i == b_i);

endmodule

// File: rtl/id_ex_load_use_detector.sv
// load_use_detector
// Combinational load-use hazard detection between the instruction in EX
// (registered ID/EX fields) and the instruction currently in ID.
//   ex_valid_i, ex_mem_read_i, ex_rd_add_i  - EX-stage load information
//   id_valid_i, id_uses_rs*_i, id_rs*_add_i - ID-stage source usage
//   haz_o                                   - ID needs the loaded value now
module load_use_detector
    import pipeline_pkg::*;
(
    input  logic                 ex_valid_i,
    input  logic                 ex_mem_read_i,
    input  logic [REG_ADD_W-1:0] ex_rd_add_i,
    input  logic                 id_valid_i,
    input  logic                 id_uses_rs1_i,
    input  logic                 id_uses_rs2_i,
    input  logic [REG_ADD_W-1:0] id_rs1_add_i,
    input  logic [REG_ADD_W-1:0] id_rs2_add_i,
    output logic                 haz_o
);

    logic rs1_eq, rs2_eq, rd_is_x0;

    Comparator_Nbit #(.N(REG_ADD_W)) u_cmp_rs1 (
        .a_i(id_rs1_add_i), .b_i(ex_rd_add_i), .eq_o(rs1_eq)
    );
    Comparator_Nbit #(.N(REG_ADD_W)) u_cmp_rs2 (
        .a_i(id_rs2_add_i), .b_i(ex_rd_add_i), .eq_o(rs2_eq)
    );
    // A load to x0 produces nothing to wait for.
    Comparator_Nbit #(.N(REG_ADD_W)) u_cmp_x0 (
        .a_i(ex_rd_add_i), .b_i(X0_ADD), .eq_o(rd_is_x0)
    );

    assign haz_o = ex_valid_i & ex_mem_read_i & ~rd_is_x0 & id_valid_i &
                   ((id_uses_rs1_i & rs1_eq) | (id_uses_rs2_i & rs2_eq));

endmodule

// File: rtl/id_ex_register.sv
// id_ex_register
// ID/EX pipeline register with built-in load-use stall and bubble insertion.
//   Clk, Rst_n              - clock, async active-low reset
//   Flush, Hold, CntClr     - kill ID instr, global freeze, clear BubbleCnt
//   IfId*, RegData*, Imm,
//   AluOp + control bits    - decoded instruction from ID
//   IdEx*                   - registered instruction driving EX / forwarding
//   Stall                   - combinational hold request to PC and IF/ID
//   BubbleCnt               - saturating count of load-use bubbles
module id_ex_register #(
    parameter int XLEN    = pipeline_pkg::XLEN,
    parameter int ALUOP_W = pipeline_pkg::ALUOP_W,
    parameter int CNT_W   = 16
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Flush,
    input  logic               Hold,
    input  logic               CntClr,
    input  logic               IfIdValid,
    input  logic [XLEN-1:0]    IfIdPc,
    input  logic [4:0]         IfIdRs1Add,
    input  logic [4:0]         IfIdRs2Add,
    input  logic [4:0]         IfIdRdAdd,
    input  logic               IfIdUsesRs1,
    input  logic               IfIdUsesRs2,
    input  logic [XLEN-1:0]    RegData1,
    input  logic [XLEN-1:0]    RegData2,
    input  logic [XLEN-1:0]    Imm,
    input  logic [ALUOP_W-1:0] AluOp,
    input  logic               AluSrc,
    input  logic               RegWrite,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic               MemToReg,
    input  logic               Branch,
    output logic               IdExValid,
    output logic [XLEN-1:0]    IdExPc,
    output logic [XLEN-1:0]    IdExData1,
    output logic [XLEN-1:0]    IdExData2,
    output logic [XLEN-1:0]    IdExImm,
    output logic [4:0]         IdExRs1Add,
    output logic [4:0]         IdExRs2Add,
    output logic [4:0]         IdExRdAdd,
    output logic [ALUOP_W-1:0] IdExAluOp,
    output logic               IdExAluSrc,
    output logic               IdExRegWrite,
    output logic               IdExMemRead,
    output logic               IdExMemWrite,
    output logic               IdExMemToReg,
    output logic               IdExBranch,
    output logic               Stall,
    output logic [CNT_W-1:0]   BubbleCnt
);
    import pipeline_pkg::*;

    logic                 valid_d, valid_q;
    logic [XLEN-1:0]      pc_d, pc_q, data1_d, data1_q, data2_d, data2_q, imm_d, imm_q;
    logic [REG_ADD_W-1:0] rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
    logic [ALUOP_W-1:0]   aluop_d, aluop_q;
    ctrl_flags_t          flags_in, flags_d, flags_q;
    logic [CNT_W-1:0]     cnt_d, cnt_q;
    logic                 haz, bubble, load;

    load_use_detector u_luse (
        .ex_valid_i   (valid_q),
        .ex_mem_read_i(flags_q.mem_read),
        .ex_rd_add_i  (rd_q),
        .id_valid_i   (IfIdValid),
        .id_uses_rs1_i(IfIdUsesRs1),
        .id_uses_rs2_i(IfIdUsesRs2),
        .id_rs1_add_i (IfIdRs1Add),
        .id_rs2_add_i (IfIdRs2Add),
        .haz_o        (haz)
    );

    assign flags_in = '{alu_src: AluSrc, reg_write: RegWrite, mem_read: MemRead,
                        mem_write: MemWrite, mem_to_reg: MemToReg, branch: Branch};

    // Flush outranks Hold; Hold outranks the hazard.
    assign bubble = Flush | (~Hold & haz);
    assign load   = ~Flush & ~Hold & ~haz;
    assign Stall  = haz & ~Flush & ~Hold;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        data1_d = data1_q;
        data2_d = data2_q;
        imm_d   = imm_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        aluop_d = aluop_q;
        flags_d = flags_q;
        if (bubble) begin
            // Pc/Data/Imm are left alone; addresses go to x0 so forwarding stays quiet.
            valid_d = 1'b0;
            rs1_d   = X0_ADD;
            rs2_d   = X0_ADD;
            rd_d    = X0_ADD;
            aluop_d = '0;
            flags_d = '0;
        end else if (load) begin
            valid_d = IfIdValid;
            pc_d    = IfIdPc;
            data1_d = RegData1;
            data2_d = RegData2;
            imm_d   = Imm;
            rs1_d   = IfIdRs1Add;
            rs2_d   = IfIdRs2Add;
            rd_d    = IfIdRdAdd;
            // An empty slot must never write anything downstream.
            aluop_d = IfIdValid ? AluOp : '0;
            flags_d = IfIdValid ? flags_in : '0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (CntClr)
            cnt_d = '0;
        else if (Stall && cnt_q != '1)
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            data1_q <= '0;
            data2_q <= '0;
            imm_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            aluop_q <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            imm_q   <= imm_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            aluop_q <= aluop_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    assign IdExValid    = valid_q;
    assign IdExPc       = pc_q;
    assign IdExData1    = data1_q;
    assign IdExData2    = data2_q;
    assign IdExImm      = imm_q;
    assign IdExRs1Add   = rs1_q;
    assign IdExRs2Add   = rs2_q;
    assign IdExRdAdd    = rd_q;
    assign IdExAluOp    = aluop_q;
    assign IdExAluSrc   = flags_q.alu_src;
    assign IdExRegWrite = flags_q.reg_write;
    assign IdExMemRead  = flags_q.mem_read;
    assign IdExMemWrite = flags_q.mem_write;
    assign IdExMemToReg = flags_q.mem_to_reg;
    assign IdExBranch   = flags_q.branch;
    assign BubbleCnt    = cnt_q;

endmodule

// File: doc/id_ex_register.md
# id_ex_register

ID/EX pipeline register of the five-stage RISC-V core, with load-use hazard detection built in. It captures the decoded instruction from the ID stage each cycle. It drives the EX-stage datapath and supplies the ForwardingUnit with IdExRs1Add/IdExRs2Add. When a load in EX is followed by a dependent instruction in ID, it raises Stall towards PC/IF-ID and inserts a bubble.

## Interface
Parameters:
- XLEN, 32, datapath width (PC, operands, immediate)
- ALUOP_W, 4, ALU control field width
- CNT_W, 16, bubble counter width

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- Flush  in  1  EX-stage taken branch/jump; kill the ID instruction
- Hold  in  1  global freeze (memory wait)
- CntClr  in  1  synchronous clear of BubbleCnt
- IfIdValid  in  1  ID holds a real instruction
- IfIdPc  in  XLEN  instruction PC
- IfIdRs1Add, IfIdRs2Add, IfIdRdAdd  in  5 each  register addresses
- IfIdUsesRs1, IfIdUsesRs2  in  1 each  instruction reads rs1/rs2
- RegData1, RegData2, Imm  in  XLEN each  register-file outputs, immediate
- AluOp  in  ALUOP_W  ALU control
- AluSrc, RegWrite, MemRead, MemWrite, MemToReg, Branch  in  1 each  decoded control
- IdExValid  out  1  registered valid
- IdExPc, IdExData1, IdExData2, IdExImm  out  XLEN  registered data
- IdExRs1Add, IdExRs2Add, IdExRdAdd  out  5  registered addresses
- IdExAluOp  out  ALUOP_W;  IdExAluSrc, IdExRegWrite, IdExMemRead, IdExMemWrite, IdExMemToReg, IdExBranch  out  1  registered control
- Stall  out  1  combinational; hold PC and IF/ID this cycle
- BubbleCnt  out  CNT_W  saturating count of load-use bubbles

## Operation
- Hazard: Haz = IdExValid & IdExMemRead & (IdExRdAdd≠0) & IfIdValid & ((IfIdUsesRs1 & IfIdRs1Add==IdExRdAdd) | (IfIdUsesRs2 & IfIdRs2Add==IdExRdAdd)).
- Stall = Haz & ~Flush & ~Hold.
- Per-edge update priority:
  1. Flush → bubble.
  2. Hold → all registers keep value.
  3. Haz → bubble.
  4. Otherwise load all fields from inputs; IdExValid ← IfIdValid.
- Bubble: IdExValid, RegWrite, MemRead, MemWrite, MemToReg, Branch, AluSrc ← 0; AluOp ← 0; Rs1Add/Rs2Add/RdAdd ← 0, so the forwarding unit sees x0. Pc/Data/Imm keep previous value.
- Load with IfIdValid=0: fields load as presented, but all control bits are forced to 0, so invalid slots never write.
- BubbleCnt:
  - CntClr → 0 (CntClr wins over an increment in the same cycle).
  - Else +1 on each hazard bubble (case 3), saturating at 2^CNT_W−1.
  - Flush bubbles are not counted.
- A single load-use stall lasts exactly one cycle. After the bubble, IdExMemRead=0, so Haz drops and the dependent instruction loads on the next edge. The forwarding unit then supplies the value from MEM/WB.

## Timing
- Registered outputs: 1-cycle latency from the ID inputs.
- Stall: same-cycle combinational from the registered IdEx* outputs and the IfId* inputs; no path from Data/Imm.
- Reset (async assert, sync-to-Clk deassert handled externally): every registered output is 0, BubbleCnt=0, so Stall=0.
- Reset mid-stall: outputs clear immediately and Stall drops in the same cycle.
- Flush and Haz together: bubble inserted, Stall=0, not counted.
- Hold and Haz together: Stall=0, nothing changes; the hazard is re-evaluated when Hold falls.

## Structure
- Shared package (pipeline_pkg): ALUOP_W, XLEN, REG_ADD_W=5, X0_ADD=5'b0, and a control-bundle width constant also used by EX/MEM.
- One sub-module: load_use_detector, purely combinational. It computes Haz and reuses Comparator_Nbit (N=5) for the address compares, as ForwardingUnit does.
- The register/priority logic and the counter stay in id_ex_register.

## Test plan
- Plain load: IfIdValid=1, Rd=5, RegWrite=1, Data1=0x1234 → next cycle IdExRdAdd=5, IdExRegWrite=1, IdExData1=0x1234, Stall=0 throughout.
- Load-use: lw x7 in EX (IdExMemRead=1, IdExRdAdd=7), ID add with Rs2=7 and UsesRs2=1 → Stall=1 for one cycle, bubble (IdExValid=0, RdAdd=0), BubbleCnt=1; next cycle the add loads and Stall=0.
- No false hazard:
  - same setup with IdExRdAdd=0 → Stall=0;
  - Rs1=7 with UsesRs1=0 → Stall=0.
- Flush with hazard present: Flush=1 together with load-use → Stall=0, bubble, BubbleCnt unchanged.
- Hold: Hold=1 for 3 cycles with changing inputs → outputs frozen, Stall=0; on release, the hazard is reasserted if still present.
- Counter: CNT_W=2, force 5 hazard bubbles → BubbleCnt saturates at 3; CntClr asserted alongside a hazard → 0. Async Rst_n low mid-stall → all outputs 0 immediately.
